jt12_slot_feed: RTL and testbench

JT12_SLOT_FEED -- requirements
Module: jt12_slot_feed

---
 rtl/jt12_slot_feed.sv | 134 +++++++++++++
 tb/tb_jt12_slot_feed.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_slot_feed.sv
// jt12_slot_feed
// Double-buffered slot table that feeds operator samples serially to the
// channel accumulator, one slot per clk_en strobe.
//
// A producer fills the write bank with {sample, sum flag} entries and raises
// commit. The bank swap waits for the end of the frame currently being
// replayed, so the accumulator never sees a frame mixed from two banks.
// Until that frame ends the write bank is locked (wr_ready low).
//
// Ports
//   clk        single clock
//   rst_n      synchronous active-low reset
//   clk_en     slot advance strobe
//   wr_en      write strobe for one slot entry
//   wr_addr    slot index to write (values >= slots are dropped)
//   wr_data    signed sample to store
//   wr_sum     sum-enable flag stored with the sample
//   commit     write bank is complete, swap at the next frame end
//   wr_ready   write bank accepts writes and commit
//   op_result  sample of the slot now presented
//   sum_en     include op_result in the sum
//   zero       frame-start marker (slot 0)
//   slot       index of the slot now presented
module jt12_slot_feed #(
   parameter int win   = 14,
   parameter int slots = 24
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clk_en,
   input  logic           wr_en,
   input  logic [4:0]     wr_addr,
   input  logic [win-1:0] wr_data,
   input  logic           wr_sum,
   input  logic           commit,
   output logic           wr_ready,
   output logic [win-1:0] op_result,
   output logic           sum_en,
   output logic           zero,
   output logic [4:0]     slot
);

   localparam int          aw   = $clog2(2 * slots);
   localparam logic [4:0]  last = 5'(slots - 1);

   // Both banks share one sample RAM: bank 0 at [0, slots), bank 1 above it.
   logic [win-1:0]          mem [0:2*slots-1];
   // Sum flags live in registers so that reset can clear all of them, which
   // makes the unreset sample RAM harmless.
   logic [1:0][slots-1:0]   flag_reg;
   logic [1:0][slots-1:0]   flag_next;

   logic                    bank_sel_reg;
   logic                    pending_reg;
   logic [4:0]              cnt_reg;
   logic [4:0]              cnt_next;
   logic [win-1:0]          op_result_reg;
   logic                    sum_en_reg;
   logic                    zero_reg;
   logic [4:0]              slot_reg;

   logic                    wr_ok;
   logic                    wr_bank;
   logic                    swap;
   logic [aw-1:0]           wr_idx;
   logic [aw-1:0]           rd_idx;

   assign wr_ready = !pending_reg;
   assign wr_bank  = !bank_sel_reg;
   assign wr_ok    = wr_en && !pending_reg && ({1'b0, wr_addr} < 6'(slots));
   // Swap only on the strobe that presents the last slot of the frame.
   assign swap     = clk_en && (cnt_reg == last) && pending_reg;
   assign cnt_next = (cnt_reg == last) ? 5'd0 : cnt_reg + 5'd1;
   assign wr_idx   = (wr_bank      ? aw'(slots) : aw'(0)) + aw'(wr_addr);
   assign rd_idx   = (bank_sel_reg ? aw'(slots) : aw'(0)) + aw'(cnt_reg);

   // Sample RAM write port (write bank only, so it never collides with reads).
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_idx] <= wr_data;
   end

   // Per-entry flag update.
   generate
      for (genvar bi = 0; bi < 2; bi++) begin : g_bank
         for (genvar gi = 0; gi < slots; gi++) begin : g_entry
            assign flag_next[bi][gi] =
               (wr_ok && (wr_bank == 1'(bi)) && (wr_addr == 5'(gi)))
               ? wr_sum : flag_reg[bi][gi];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n)
         flag_reg <= '0;
      else
         flag_reg <= flag_next;
   end

   // Slot counter, bank control and registered RAM read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg       <= '0;
         bank_sel_reg  <= 1'b0;
         pending_reg   <= 1'b0;
         op_result_reg <= '0;
         sum_en_reg    <= 1'b0;
         zero_reg      <= 1'b0;
         slot_reg      <= '0;
      end else begin
         if (clk_en) begin
            cnt_reg       <= cnt_next;
            op_result_reg <= mem[rd_idx];
            sum_en_reg    <= flag_reg[bank_sel_reg][cnt_reg];
            zero_reg      <= (cnt_reg == 5'd0);
            slot_reg      <= cnt_reg;
         end
         // A commit arriving on the swap cycle sees wr_ready low; the swap wins.
         if (swap) begin
            bank_sel_reg <= !bank_sel_reg;
            pending_reg  <= 1'b0;
         end else if (commit && !pending_reg) begin
            pending_reg  <= 1'b1;
         end
      end
   end

   assign op_result = op_result_reg;
   assign sum_en    = sum_en_reg;
   assign zero      = zero_reg;
   assign slot      = slot_reg;

endmodule

// File: tb/tb_jt12_slot_feed.sv
// Testbench for jt12_slot_feed: frame-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_jt12_slot_feed;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        clk_en  = 1'b0;
   logic        wr_en   = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [13:0] wr_data = '0;
   logic        wr_sum  = 1'b0;
   logic        commit  = 1'b0;
   logic        wr_ready;
   logic [13:0] op_result;
   logic        sum_en;
   logic        zero;
   logic [4:0]  slot;

   jt12_slot_feed #(.win(14), .slots(24)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clk_en   (clk_en),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_sum   (wr_sum),
      .commit   (commit),
      .wr_ready (wr_ready),
      .op_result(op_result),
      .sum_en   (sum_en),
      .zero     (zero),
      .slot     (slot)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [13:0] m_samp  [2][24];
   bit          m_flag  [2][24];
   bit          m_known [2][24];
   int          m_cnt   = 0;
   int          m_read  = 0;   // read bank index
   bit          m_pend  = 0;
   logic [13:0] e_op    = '0;
   bit          e_known = 0;
   bit          e_sum   = 0;
   bit          e_zero  = 0;
   int          e_slot  = 0;
   bit          chk_on  = 0;

   initial begin
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 24; i++) begin
            m_flag[b][i]  = 0;
            m_known[b][i] = 0;
            m_samp[b][i]  = '0;
         end
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         m_cnt = 0; m_read = 0; m_pend = 0;
         e_op = '0; e_known = 1; e_sum = 0; e_zero = 0; e_slot = 0;
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < 24; i++) m_flag[b][i] = 0;
      end else begin
         bit ready;
         bit do_swap;
         ready   = !m_pend;
         do_swap = clk_en && (m_cnt == 23) && m_pend;
         if (wr_en && ready && wr_addr < 24) begin
            m_samp [1 - m_read][wr_addr] = wr_data;
            m_flag [1 - m_read][wr_addr] = wr_sum;
            m_known[1 - m_read][wr_addr] = 1;
         end
         if (clk_en) begin
            e_op    = m_samp [m_read][m_cnt];
            e_known = m_known[m_read][m_cnt];
            e_sum   = m_flag [m_read][m_cnt];
            e_zero  = (m_cnt == 0);
            e_slot  = m_cnt;
            m_cnt   = (m_cnt + 1) % 24;
         end
         if (do_swap) begin
            m_read = 1 - m_read;
            m_pend = 0;
         end else if (commit && ready) begin
            m_pend = 1;
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         check("wr_ready", int'(wr_ready), int'(!m_pend));
         check("slot",     int'(slot),     e_slot);
         check("zero",     int'(zero),     int'(e_zero));
         check("sum_en",   int'(sum_en),   int'(e_sum));
         if (e_known)
            check("op_result", int'(op_result), int'(e_op));
      end
   end

   // Pulse clk_en until the given slot is presented (bounded).
   task automatic run_to_slot(input int s);
      int k;
      k = 0;
      clk_en = 1'b1;
      do begin
         @(negedge clk);
         k++;
      end while (int'(slot) != s && k < 60);
      clk_en = 1'b0;
      check("run_to_slot", int'(slot), s);
   endtask

   initial begin
      // Reset
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_on = 1;
      check("rst_slot", int'(slot), 0);
      check("rst_zero", int'(zero), 0);
      check("rst_sum",  int'(sum_en), 0);
      check("rst_op",   int'(op_result), 0);
      check("rst_rdy",  int'(wr_ready), 1);
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset done: slot=%0d zero=%0b wr_ready=%0b", slot, zero, wr_ready);

      // One empty frame
      clk_en = 1'b1;
      @(negedge clk);
      check("f0_zero", int'(zero), 1);
      check("f0_slot", int'(slot), 0);
      repeat (23) @(negedge clk);
      clk_en = 1'b0;
      check("f0_last",  int'(slot), 23);
      check("f0_lastz", int'(zero), 0);
      $display("empty frame: last slot=%0d sum_en=%0b", slot, sum_en);

      // Fill write bank: slot 0 and 5 at the positive/negative extremes
      wr_en = 1'b1; wr_sum = 1'b1;
      wr_addr = 5'd0; wr_data = 14'h1FFF; @(negedge clk);
      wr_addr = 5'd5; wr_data = 14'h2000; @(negedge clk);
      wr_en = 1'b0; wr_sum = 1'b0;
      $display("write slot0=0x1fff slot5=0x2000");

      // Freeze at slot 7 for 10 cycles, commit lands meanwhile
      run_to_slot(7);
      repeat (4) @(negedge clk);
      commit = 1'b1; @(negedge clk); commit = 1'b0;
      check("commit_rdy", int'(wr_ready), 0);
      repeat (5) @(negedge clk);
      check("frozen_slot", int'(slot), 7);
      $display("frozen at slot %0d, wr_ready=%0b", slot, wr_ready);

      // Ignored write and commit while pending
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 14'h0123; wr_sum = 1'b1; commit = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; wr_sum = 1'b0; commit = 1'b0;
      check("pend_rdy", int'(wr_ready), 0);
      $display("ignored write to slot3 while pending");

      // Frame end: swap, with a commit on the swap cycle that must be ignored
      run_to_slot(22);
      check("pre_swap_rdy", int'(wr_ready), 0);
      clk_en = 1'b1; commit = 1'b1;
      @(negedge clk);
      clk_en = 1'b0; commit = 1'b0;
      check("swap_slot", int'(slot), 23);
      check("swap_rdy",  int'(wr_ready), 1);
      $display("swap at slot %0d wr_ready=%0b", slot, wr_ready);

      // New frame
      run_to_slot(0);
      check("n0_op",  int'(op_result), 'h1FFF);
      check("n0_sum", int'(sum_en), 1);
      check("n0_z",   int'(zero), 1);
      run_to_slot(3);
      check("n3_sum", int'(sum_en), 0);
      run_to_slot(5);
      check("n5_op",  int'(op_result), 'h2000);
      check("n5_sum", int'(sum_en), 1);
      $display("new frame: slot0/5 carry samples, slot3 sum_en=%0b", sum_en);

      // Out-of-range writes are dropped; replayed frame unchanged
      wr_en = 1'b1; wr_sum = 1'b1; wr_data = 14'h0555;
      wr_addr = 5'd24; @(negedge clk);
      wr_addr = 5'd31; @(negedge clk);
      wr_en = 1'b0; wr_sum = 1'b0;
      run_to_slot(23);
      run_to_slot(0);
      check("rp0_op",  int'(op_result), 'h1FFF);
      check("rp0_sum", int'(sum_en), 1);
      run_to_slot(5);
      check("rp5_op",  int'(op_result), 'h2000);
      $display("replay after out-of-range writes: slot5 op=0x%0h", op_result);

      // Reset mid-frame with a commit pending
      commit = 1'b1; @(negedge clk); commit = 1'b0;
      check("rc_pend", int'(wr_ready), 0);
      run_to_slot(12);
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      check("rc_rdy", int'(wr_ready), 1);
      clk_en = 1'b1; @(negedge clk); clk_en = 1'b0;
      check("rc_slot", int'(slot), 0);
      check("rc_zero", int'(zero), 1);
      check("rc_sum",  int'(sum_en), 0);
      check("rc_rdy2", int'(wr_ready), 1);
      $display("after mid-frame reset: slot=%0d zero=%0b", slot, zero);
      run_to_slot(23);
      $display("post-reset frame done");

      chk_on = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
